// File: rtl/m_load_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module      : m_load_unit_pkg
// Description : Load type codes, address map, FSM encoding and request-time
//               fault check shared by the M-stage load unit.
// Revision    : 1.0 - initial release
// ============================================================================
package m_load_unit_pkg;

    // Load type codes carried on de_sel
    localparam logic [2:0] c_de_none = 3'd0;
    localparam logic [2:0] c_de_lw   = 3'd1;
    localparam logic [2:0] c_de_lh   = 3'd2;
    localparam logic [2:0] c_de_lhu  = 3'd3;
    localparam logic [2:0] c_de_lb   = 3'd4;
    localparam logic [2:0] c_de_lbu  = 3'd5;

    // Readable regions: data memory and the two timer register blocks
    localparam logic [31:0] c_start_dm = 32'h0000_0000;
    localparam logic [31:0] c_end_dm   = 32'h0000_2fff;
    localparam logic [31:0] c_start_t1 = 32'h0000_7f00;
    localparam logic [31:0] c_end_t1   = 32'h0000_7f0b;
    localparam logic [31:0] c_start_t2 = 32'h0000_7f10;
    localparam logic [31:0] c_end_t2   = 32'h0000_7f1b;

    localparam int         c_state_w  = 3;
    localparam logic [2:0] c_st_idle  = 3'd0;
    localparam logic [2:0] c_st_req   = 3'd1;
    localparam logic [2:0] c_st_wait  = 3'd2;
    localparam logic [2:0] c_st_done  = 3'd3;
    localparam logic [2:0] c_st_drain = 3'd4;

    typedef struct packed {
        logic misalign;
        logic rng;
        logic timer;
        logic ovf;
    } fault_t;

    // Unsigned offset compare avoids a constant-true test when lo is zero
    function automatic logic f_in_rng(input logic [31:0] a,
                                      input logic [31:0] lo,
                                      input logic [31:0] hi);
        return (a - lo) <= (hi - lo);
    endfunction

    function automatic fault_t f_check(input logic [31:0] addr,
                                       input logic [2:0]  sel,
                                       input logic        exdm);
        fault_t f;
        f.misalign = ((sel == c_de_lw) && (addr[1:0] != 2'b00)) ||
                     (((sel == c_de_lh) || (sel == c_de_lhu)) && addr[0]);
        f.rng      = !(f_in_rng(addr, c_start_dm, c_end_dm) ||
                       f_in_rng(addr, c_start_t1, c_end_t1) ||
                       f_in_rng(addr, c_start_t2, c_end_t2));
        // Timer registers only accept full-word reads
        f.timer    = (sel != c_de_lw) && (addr >= c_start_t1);
        f.ovf      = exdm;
        return f;
    endfunction

endpackage
`default_nettype wire

// File: rtl/m_load_ext.sv
`default_nettype none
// ============================================================================
// Module      : m_load_ext
// Description : Combinational byte/half extractor with sign or zero extension.
// Revision    : 1.0 - initial release
// ============================================================================
module m_load_ext
    import m_load_unit_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  addr_lo,
    input  logic [2:0]  de_sel,
    output logic [31:0] ld_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte = rdata[{addr_lo, 3'b000} +: 8];
        w_half = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    end

    always_comb begin
        case (de_sel)
            c_de_lb:  ld_data = {{24{w_byte[7]}}, w_byte};
            c_de_lbu: ld_data = {24'h00_0000, w_byte};
            c_de_lh:  ld_data = {{16{w_half[15]}}, w_half};
            c_de_lhu: ld_data = {16'h0000, w_half};
            default:  ld_data = rdata;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/m_load_unit.sv
`default_nettype none
// ============================================================================
// Module      : m_load_unit
// Description : M-stage load unit: fault check, req/gnt/rvalid bus read,
//               extraction and pipeline stall. Optional bus watchdog is
//               enabled by defining LOAD_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module m_load_unit
    import m_load_unit_pkg::*;
`ifdef LOAD_TIMEOUT_EN
#(
    parameter int TIMEOUT_CYCLES = 15
)
`endif
(
    input  logic        clk,
    input  logic        reset,
    input  logic        ld_valid,
    input  logic [31:0] Rdm_addr,
    input  logic [2:0]  de_sel,
    input  logic        EXdm,
    input  logic        flush,
    output logic        bus_req,
    output logic [31:0] bus_addr,
    input  logic        bus_gnt,
    input  logic        bus_rvalid,
    input  logic [31:0] bus_rdata,
    output logic        busy,
    output logic        ld_done,
    output logic [31:0] ld_data,
    output logic        EXadel
);

    logic [c_state_w-1:0] r_state;
    logic [c_state_w-1:0] w_next;
    logic [31:0]          r_addr;
    logic [2:0]           r_sel;
    logic [31:0]          r_rdata;
    logic                 r_exc;

    fault_t               w_fault;
    logic                 w_fault_any;
    logic                 w_is_load;
    logic                 w_accept;
    logic                 w_timeout;
    logic [31:0]          w_ext;

    assign w_fault     = f_check(Rdm_addr, de_sel, EXdm);
    assign w_fault_any = |w_fault;
    assign w_is_load   = de_sel inside {c_de_lw, c_de_lh, c_de_lhu, c_de_lb, c_de_lbu};
    // A pending flush blocks new requests so nothing starts behind an exception
    assign w_accept    = (r_state == c_st_idle) && ld_valid && !flush && w_is_load;

`ifdef LOAD_TIMEOUT_EN
    localparam int c_wdog_w = ($clog2(TIMEOUT_CYCLES + 1) > 4) ?
                              $clog2(TIMEOUT_CYCLES + 1) : 4;

    logic [c_wdog_w-1:0] r_wdog;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wdog <= '0;
        end else if ((r_state == c_st_req) || (r_state == c_st_wait)) begin
            r_wdog <= r_wdog + 1'b1;
        end else begin
            r_wdog <= '0;
        end
    end

    assign w_timeout = ((r_state == c_st_req) || (r_state == c_st_wait)) &&
                       (r_wdog == c_wdog_w'(TIMEOUT_CYCLES - 1));
`else
    assign w_timeout = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            c_st_idle: begin
                if (w_accept) begin
                    w_next = w_fault_any ? c_st_done : c_st_req;
                end
            end
            c_st_req: begin
                if (flush) begin
                    // Granted but unanswered reads must be drained before reuse
                    w_next = (bus_gnt && !bus_rvalid) ? c_st_drain : c_st_idle;
                end else if (bus_gnt && bus_rvalid) begin
                    w_next = c_st_done;
                end else if (bus_gnt) begin
                    w_next = c_st_wait;
                end else if (w_timeout) begin
                    w_next = c_st_done;
                end
            end
            c_st_wait: begin
                if (flush) begin
                    w_next = bus_rvalid ? c_st_idle : c_st_drain;
                end else if (bus_rvalid || w_timeout) begin
                    w_next = c_st_done;
                end
            end
            c_st_done: begin
                w_next = c_st_idle;
            end
            c_st_drain: begin
                if (bus_rvalid) begin
                    w_next = c_st_idle;
                end
            end
            default: begin
                w_next = c_st_idle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_addr  <= '0;
            r_sel   <= c_de_none;
            r_rdata <= '0;
            r_exc   <= 1'b0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (w_accept) begin
                        r_addr  <= Rdm_addr;
                        r_sel   <= de_sel;
                        r_rdata <= '0;
                        r_exc   <= w_fault_any;
                    end
                end
                c_st_req: begin
                    if (bus_gnt && bus_rvalid) begin
                        r_rdata <= bus_rdata;
                    end else if (!bus_gnt && w_timeout) begin
                        r_exc <= 1'b1;
                    end
                end
                c_st_wait: begin
                    if (bus_rvalid) begin
                        r_rdata <= bus_rdata;
                    end else if (w_timeout) begin
                        r_exc <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    m_load_ext u_ext (
        .rdata   (r_rdata),
        .addr_lo (r_addr[1:0]),
        .de_sel  (r_sel),
        .ld_data (w_ext)
    );

    always_comb begin
        bus_req  = (r_state == c_st_req);
        bus_addr = bus_req ? {r_addr[31:2], 2'b00} : 32'h0000_0000;
        busy     = (r_state != c_st_idle);
        ld_done  = (r_state == c_st_done) && !flush;
        EXadel   = ld_done && r_exc;
        ld_data  = (ld_done && !r_exc) ? w_ext : 32'h0000_0000;
    end

endmodule
`default_nettype wire

// File: tb/tb_m_load_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_m_load_unit
// Description : Directed, table-driven bench for m_load_unit.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_m_load_unit;
    import m_load_unit_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        ld_valid = 1'b0;
    logic [31:0] Rdm_addr = '0;
    logic [2:0]  de_sel = c_de_none;
    logic        EXdm = 1'b0;
    logic        flush = 1'b0;
    logic        bus_req;
    logic [31:0] bus_addr;
    logic        bus_gnt = 1'b0;
    logic        bus_rvalid = 1'b0;
    logic [31:0] bus_rdata = '0;
    logic        busy;
    logic        ld_done;
    logic [31:0] ld_data;
    logic        EXadel;

    int n_checks = 0;
    int n_errors = 0;

    m_load_unit dut (
        .clk        (clk),
        .reset      (reset),
        .ld_valid   (ld_valid),
        .Rdm_addr   (Rdm_addr),
        .de_sel     (de_sel),
        .EXdm       (EXdm),
        .flush      (flush),
        .bus_req    (bus_req),
        .bus_addr   (bus_addr),
        .bus_gnt    (bus_gnt),
        .bus_rvalid (bus_rvalid),
        .bus_rdata  (bus_rdata),
        .busy       (busy),
        .ld_done    (ld_done),
        .ld_data    (ld_data),
        .EXadel     (EXadel)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  sel;
        logic [31:0] addr;
        logic        exdm;
        logic [31:0] rdata;
        logic        exp_exc;
        logic [31:0] exp_data;
    } vec_t;

    localparam int NV = 17;
    vec_t vecs [NV];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Zero-wait bus: grant and return data in the first REQ cycle
    task automatic run_vec(input vec_t v, input int id);
        int   cyc;
        bit   seen_req;
        bit   seen_done;
        logic [31:0] got_data;
        logic got_exc;
        cyc = 0; seen_req = 0; seen_done = 0; got_data = '0; got_exc = 1'b0;
        ld_valid = 1'b1; de_sel = v.sel; Rdm_addr = v.addr; EXdm = v.exdm;
        while (!seen_done && cyc < 8) begin
            tick();
            cyc++;
            ld_valid = 1'b0; EXdm = 1'b0;
            bus_gnt = 1'b0; bus_rvalid = 1'b0;
            if (ld_done) begin
                seen_done = 1;
                got_data  = ld_data;
                got_exc   = EXadel;
            end else if (bus_req) begin
                if (!seen_req)
                    chk($sformatf("vec%0d bus_addr", id), bus_addr, v.addr & 32'hffff_fffc);
                seen_req   = 1;
                bus_gnt    = 1'b1;
                bus_rvalid = 1'b1;
                bus_rdata  = v.rdata;
            end
        end
        chk($sformatf("vec%0d done_seen", id), 32'(seen_done), 32'd1);
        chk($sformatf("vec%0d latency", id), 32'(cyc), v.exp_exc ? 32'd1 : 32'd2);
        chk($sformatf("vec%0d bus_req_seen", id), 32'(seen_req), 32'(!v.exp_exc));
        chk($sformatf("vec%0d ld_data", id), got_data, v.exp_data);
        chk($sformatf("vec%0d EXadel", id), 32'(got_exc), 32'(v.exp_exc));
        tick();
        chk($sformatf("vec%0d busy_after", id), 32'(busy), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int busy_cnt;
        int done_cnt;
        logic [31:0] cap;

        vecs[0]  = '{c_de_lb,  32'h0000_0003, 1'b0, 32'h80ff_1234, 1'b0, 32'hffff_ff80};
        vecs[1]  = '{c_de_lhu, 32'h0000_0002, 1'b0, 32'h8001_0000, 1'b0, 32'h0000_8001};
        vecs[2]  = '{c_de_lw,  32'h0000_0002, 1'b0, 32'h1111_1111, 1'b1, 32'h0000_0000};
        vecs[3]  = '{c_de_lh,  32'h0000_7f00, 1'b0, 32'h1111_1111, 1'b1, 32'h0000_0000};
        vecs[4]  = '{c_de_lw,  32'h0000_7f08, 1'b0, 32'h1234_5678, 1'b0, 32'h1234_5678};
        vecs[5]  = '{c_de_lbu, 32'h0000_0001, 1'b0, 32'h1234_a5c3, 1'b0, 32'h0000_00a5};
        vecs[6]  = '{c_de_lb,  32'h0000_0001, 1'b0, 32'h1234_a5c3, 1'b0, 32'hffff_ffa5};
        vecs[7]  = '{c_de_lh,  32'h0000_0000, 1'b0, 32'h1234_8001, 1'b0, 32'hffff_8001};
        vecs[8]  = '{c_de_lh,  32'h0000_0002, 1'b0, 32'h7fff_0000, 1'b0, 32'h0000_7fff};
        vecs[9]  = '{c_de_lw,  32'h0000_2ffc, 1'b0, 32'hdead_beef, 1'b0, 32'hdead_beef};
        vecs[10] = '{c_de_lw,  32'h0000_3000, 1'b0, 32'h1111_1111, 1'b1, 32'h0000_0000};
        vecs[11] = '{c_de_lw,  32'h0000_7f1c, 1'b0, 32'h1111_1111, 1'b1, 32'h0000_0000};
        vecs[12] = '{c_de_lw,  32'h0000_7f18, 1'b0, 32'h0bad_cafe, 1'b0, 32'h0bad_cafe};
        vecs[13] = '{c_de_lb,  32'h0000_0000, 1'b1, 32'h1111_1111, 1'b1, 32'h0000_0000};
        vecs[14] = '{c_de_lh,  32'h0000_0001, 1'b0, 32'h1111_1111, 1'b1, 32'h0000_0000};
        vecs[15] = '{c_de_lb,  32'h0000_0002, 1'b0, 32'h1234_a5c3, 1'b0, 32'h0000_0034};
        vecs[16] = '{c_de_lw,  32'h0000_7f0c, 1'b0, 32'h1111_1111, 1'b1, 32'h0000_0000};

        // Reset state
        repeat (3) tick();
        chk("rst busy", 32'(busy), 32'd0);
        chk("rst bus_req", 32'(bus_req), 32'd0);
        chk("rst bus_addr", bus_addr, 32'd0);
        chk("rst ld_done", 32'(ld_done), 32'd0);
        chk("rst ld_data", ld_data, 32'd0);
        chk("rst EXadel", 32'(EXadel), 32'd0);
        reset = 1'b0;
        tick();

        for (int i = 0; i < NV; i++) run_vec(vecs[i], i);

        // ld_valid with no load type, and with flush in IDLE, is ignored
        ld_valid = 1'b1; de_sel = c_de_none; Rdm_addr = 32'h0000_0010;
        tick();
        ld_valid = 1'b0;
        chk("none busy", 32'(busy), 32'd0);
        ld_valid = 1'b1; de_sel = c_de_lw; flush = 1'b1;
        tick();
        ld_valid = 1'b0; flush = 1'b0;
        chk("flush_idle busy", 32'(busy), 32'd0);

        // Delayed grant (3rd REQ cycle) and rvalid two cycles later
        busy_cnt = 0; done_cnt = 0; cap = '0;
        ld_valid = 1'b1; de_sel = c_de_lw; Rdm_addr = 32'h0000_0010;
        for (int c = 1; c <= 10; c++) begin
            tick();
            ld_valid = 1'b0;
            if (busy) busy_cnt++;
            if (ld_done) begin done_cnt++; cap = ld_data; end
            if (c == 2) chk("slow bus_addr", bus_addr, 32'h0000_0010);
            if (c == 4) chk("slow wait no req", 32'(bus_req), 32'd0);
            bus_gnt    = (c == 3);
            bus_rvalid = (c == 5);
            bus_rdata  = (c == 5) ? 32'hcafe_f00d : 32'h0;
        end
        chk("slow busy cycles", 32'(busy_cnt), 32'd6);
        chk("slow done pulses", 32'(done_cnt), 32'd1);
        chk("slow ld_data", cap, 32'hcafe_f00d);

        // Flush in WAIT -> DRAIN; the late rvalid produces no completion
        done_cnt = 0;
        ld_valid = 1'b1; de_sel = c_de_lw; Rdm_addr = 32'h0000_0020;
        tick();
        ld_valid = 1'b0; bus_gnt = 1'b1;
        tick();
        bus_gnt = 1'b0; flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("drain busy", 32'(busy), 32'd1);
        if (ld_done) done_cnt++;
        tick();
        if (ld_done) done_cnt++;
        chk("drain still busy", 32'(busy), 32'd1);
        bus_rvalid = 1'b1; bus_rdata = 32'h5555_5555;
        tick();
        bus_rvalid = 1'b0;
        if (ld_done) done_cnt++;
        chk("drain exit busy", 32'(busy), 32'd0);
        tick();
        if (ld_done) done_cnt++;
        chk("drain no done", 32'(done_cnt), 32'd0);
        run_vec('{c_de_lw, 32'h0000_0024, 1'b0, 32'h7654_3210, 1'b0, 32'h7654_3210}, 100);

        // Flush in REQ before grant returns straight to IDLE
        ld_valid = 1'b1; de_sel = c_de_lw; Rdm_addr = 32'h0000_0030;
        tick();
        ld_valid = 1'b0; flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("flush_req busy", 32'(busy), 32'd0);
        chk("flush_req bus_req", 32'(bus_req), 32'd0);

        // Flush in DONE suppresses the completion pulse
        ld_valid = 1'b1; de_sel = c_de_lw; Rdm_addr = 32'h0000_0000;
        tick();
        ld_valid = 1'b0; bus_gnt = 1'b1; bus_rvalid = 1'b1; bus_rdata = 32'h0000_0011;
        tick();
        bus_gnt = 1'b0; bus_rvalid = 1'b0;
        chk("done busy", 32'(busy), 32'd1);
        flush = 1'b1;
        #1;
        chk("flush_done ld_done", 32'(ld_done), 32'd0);
        tick();
        flush = 1'b0;
        chk("flush_done busy", 32'(busy), 32'd0);

        // Asynchronous reset in the middle of a request
        ld_valid = 1'b1; de_sel = c_de_lw; Rdm_addr = 32'h0000_0040;
        tick();
        ld_valid = 1'b0;
        chk("pre_rst bus_req", 32'(bus_req), 32'd1);
        #2 reset = 1'b1;
        #1;
        chk("async_rst busy", 32'(busy), 32'd0);
        chk("async_rst bus_req", 32'(bus_req), 32'd0);
        tick();
        reset = 1'b0;
        tick();

`ifdef LOAD_TIMEOUT_EN
        // Watchdog: no grant ever arrives
        begin
            int cyc;
            bit seen;
            logic [31:0] d;
            logic e;
            cyc = 0; seen = 0; d = '1; e = 1'b0;
            ld_valid = 1'b1; de_sel = c_de_lw; Rdm_addr = 32'h0000_0050;
            while (!seen && cyc < 40) begin
                tick();
                cyc++;
                ld_valid = 1'b0;
                if (ld_done) begin seen = 1; d = ld_data; e = EXadel; end
            end
            chk("tmo seen", 32'(seen), 32'd1);
            chk("tmo cycle", 32'(cyc), 32'd16);
            chk("tmo EXadel", 32'(e), 32'd1);
            chk("tmo ld_data", d, 32'd0);
            bus_rvalid = 1'b1;
            tick();
            bus_rvalid = 1'b0;
            chk("stray busy", 32'(busy), 32'd0);
            chk("stray ld_done", 32'(ld_done), 32'd0);
        end
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
